// File: rtl/dbg_spi_slave.sv
// dbg_spi_slave: debug SPI slave at the front of the NanoController.
// Decodes 2-byte (command, data) transactions, MSB first, SPI mode 0, and
// turns them into configuration-memory write strobes, clock-enable config,
// core reset hold and, optionally, a read-back status byte.
// Optional feature macro: DBG_SPI_READBACK_EN enables the op 0x9 read path;
// without it op 0x9 is dropped and MISO stays low.
module dbg_spi_slave #(
  parameter int CLUT_SIZE     = 21,
  parameter int SCHG_SIZE     = 16,
  parameter int IMEM_SIZE     = 128,
  parameter bit RST_HOLD_INIT = 1'b1
) (
  input  logic       i_nano_clk,
  input  logic       i_nano_rst,
  input  logic       i_dbg_spi_en_n,
  input  logic       i_dbg_spi_sclk,
  input  logic       i_dbg_spi_mosi,
  output logic       o_dbg_spi_miso,
  output logic       o_wr_en,
  output logic [1:0] o_wr_tgt,
  output logic [6:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_core_rst,
  output logic [7:0] o_clken_cfg,
  output logic [3:0] o_rd_sel,
  input  logic [7:0] i_rd_data
);

  localparam logic [1:0] S_CMD   = 2'd0;
  localparam logic [1:0] S_WDATA = 2'd1;
  localparam logic [1:0] S_RDATA = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

  localparam logic [1:0] TGT_CLUT     = 2'd0;
  localparam logic [1:0] TGT_SCHG_LSB = 2'd1;
  localparam logic [1:0] TGT_SCHG_MSB = 2'd2;
  localparam logic [1:0] TGT_IMEM     = 2'd3;

  // Limits widened to 8 bits so a 128-entry IMEM is representable.
  localparam logic [7:0] CLUT_LIM = 8'(CLUT_SIZE);
  localparam logic [7:0] SCHG_LIM = 8'(SCHG_SIZE);
  localparam logic [7:0] IMEM_LIM = 8'(IMEM_SIZE);

  logic [1:0] en_n_sync;
  logic [1:0] sclk_sync;
  logic [1:0] mosi_sync;
  logic       sclk_d;
  logic       en_n_s;
  logic       sclk_s;
  logic       mosi_s;
  logic       armed;
  logic       bit_stb;
  logic       byte_done;
  logic [7:0] rx_byte;

  logic [7:0] rx_sr;
  logic [2:0] bit_cnt;
  logic [1:0] state;
  logic [3:0] cmd_op;
  logic       cmd_lsb;
  logic       act_pend;
  logic [7:0] act_data;
  logic       is_wop;
  logic       is_rop;

  logic [6:0] addr_cnt;
  logic       err;
  logic [1:0] wr_tgt_sel;
  logic [7:0] wr_lim;

  assign en_n_s    = en_n_sync[1];
  assign sclk_s    = sclk_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign bit_stb   = sclk_s & ~sclk_d & ~en_n_s & armed;
  assign byte_done = bit_stb & (bit_cnt == 3'd7);
  assign rx_byte   = {rx_sr[6:0], mosi_s};

  // Two-flop synchronizers plus the sclk delay tap used for edge detection.
  // en_n resets to "low" so that a chip-select already active across reset is
  // not mistaken for a fresh one; arming waits for a really observed high.
  always_ff @(posedge i_nano_clk) begin
    if (i_nano_rst) begin
      en_n_sync <= 2'b00;
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      sclk_d    <= 1'b0;
      armed     <= 1'b0;
    end else begin
      en_n_sync <= {en_n_sync[0], i_dbg_spi_en_n};
      sclk_sync <= {sclk_sync[0], i_dbg_spi_sclk};
      mosi_sync <= {mosi_sync[0], i_dbg_spi_mosi};
      sclk_d    <= sclk_s;
      if (en_n_s) armed <= 1'b1;
    end
  end

  // Command ops that are followed by a data byte carrying a write action.
  always_comb begin
    is_wop = 1'b0;
    case (rx_byte[7:4])
      4'h0, 4'h2, 4'h3, 4'h6, 4'h7: is_wop = 1'b1;
      default: is_wop = 1'b0;
    endcase
`ifdef DBG_SPI_READBACK_EN
    is_rop = (rx_byte[7:4] == 4'h9);
`else
    is_rop = 1'b0;
`endif
  end

  // Bit shifting, byte framing and the transaction state machine.
  always_ff @(posedge i_nano_clk) begin
    if (i_nano_rst) begin
      rx_sr    <= 8'h00;
      bit_cnt  <= 3'd0;
      state    <= S_CMD;
      cmd_op   <= 4'h0;
      cmd_lsb  <= 1'b0;
      act_pend <= 1'b0;
      act_data <= 8'h00;
    end else begin
      act_pend <= 1'b0;
      if (en_n_s) begin
        bit_cnt <= 3'd0;
        state   <= S_CMD;
      end else if (bit_stb) begin
        rx_sr   <= rx_byte;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          case (state)
            S_CMD: begin
              if (is_wop) begin
                state   <= S_WDATA;
                cmd_op  <= rx_byte[7:4];
                cmd_lsb <= rx_byte[0];
              end else if (is_rop) begin
                state <= S_RDATA;
              end else begin
                state <= S_DROP;
              end
            end
            S_WDATA: begin
              act_pend <= 1'b1;
              act_data <= rx_byte;
              state    <= S_CMD;
            end
            default: state <= S_CMD;
          endcase
        end
      end
    end
  end

  // Target lane and depth limit for the latched memory-write command.
  always_comb begin
    wr_tgt_sel = TGT_IMEM;
    wr_lim     = IMEM_LIM;
    case (cmd_op)
      4'h6: begin
        wr_tgt_sel = TGT_CLUT;
        wr_lim     = CLUT_LIM;
      end
      4'h7: begin
        wr_tgt_sel = cmd_lsb ? TGT_SCHG_MSB : TGT_SCHG_LSB;
        wr_lim     = SCHG_LIM;
      end
      default: begin
        wr_tgt_sel = TGT_IMEM;
        wr_lim     = IMEM_LIM;
      end
    endcase
  end

  // Executes a completed write transaction one cycle after its data byte.
  always_ff @(posedge i_nano_clk) begin
    if (i_nano_rst) begin
      o_wr_en     <= 1'b0;
      o_wr_tgt    <= TGT_CLUT;
      o_wr_addr   <= 7'd0;
      o_wr_data   <= 8'h00;
      o_core_rst  <= RST_HOLD_INIT;
      o_clken_cfg <= 8'h00;
      addr_cnt    <= 7'd0;
      err         <= 1'b0;
    end else begin
      o_wr_en <= 1'b0;
      if (act_pend) begin
        case (cmd_op)
          4'h0: begin
            o_core_rst <= act_data[0];
            addr_cnt   <= 7'd0;
            err        <= 1'b0;
          end
          4'h2: o_clken_cfg <= act_data;
          default: begin
            addr_cnt <= addr_cnt + 7'd1;
            if ({1'b0, addr_cnt} < wr_lim) begin
              o_wr_en   <= 1'b1;
              o_wr_tgt  <= wr_tgt_sel;
              o_wr_addr <= addr_cnt;
              o_wr_data <= act_data;
            end else begin
              err <= 1'b1;
            end
          end
        endcase
      end
    end
  end

`ifdef DBG_SPI_READBACK_EN
  logic       sclk_fall;
  logic       rd_start;
  logic [7:0] tx_sr;
  logic [7:0] rd_load;

  // The first falling edge after the command byte is skipped (bit_cnt still
  // 0) so bit 7 stays on MISO until the master samples it.
  assign sclk_fall = ~sclk_s & sclk_d & ~en_n_s & armed & (state == S_RDATA) & (bit_cnt != 3'd0);
  assign rd_start  = byte_done & (state == S_CMD) & is_rop;
  assign rd_load   = (rx_byte[3:0] == 4'hF) ? {err, o_core_rst, 6'b0} : i_rd_data;

  // Read path: load the status/read byte on decode, shift out on falling sclk.
  always_ff @(posedge i_nano_clk) begin
    if (i_nano_rst) begin
      tx_sr          <= 8'h00;
      o_dbg_spi_miso <= 1'b0;
      o_rd_sel       <= 4'h0;
    end else if (en_n_s) begin
      o_dbg_spi_miso <= 1'b0;
    end else if (rd_start) begin
      o_rd_sel       <= rx_byte[3:0];
      tx_sr          <= rd_load;
      o_dbg_spi_miso <= rd_load[7];
    end else if (sclk_fall) begin
      tx_sr          <= {tx_sr[6:0], 1'b0};
      o_dbg_spi_miso <= tx_sr[6];
    end
  end
`else
  logic unused_rd;

  // Read-back disabled: MISO and read select are constant.
  assign o_dbg_spi_miso = 1'b0;
  assign o_rd_sel       = 4'h0;
  assign unused_rd      = ^i_rd_data;
`endif

endmodule

// File: tb/tb_dbg_spi_slave.sv
// tb_dbg_spi_slave: randomized and directed stimulus for dbg_spi_slave,
// checked against a transaction-level model of the debug SPI protocol.
// Expectations follow DBG_SPI_READBACK_EN when it is defined.
module tb_dbg_spi_slave;

  logic       clk;
  logic       rst;
  logic       spi_en_n;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       wr_en;
  logic [1:0] wr_tgt;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       core_rst;
  logic [7:0] clken_cfg;
  logic [3:0] rd_sel;
  logic [7:0] rd_data;

  int nChecks = 0;
  int nFail   = 0;
  int cycle   = 0;
  int riseCycle = 0;

  // Model state
  logic [16:0] expQ[$];
  logic       mCore;
  logic [7:0] mClk;
  int         mCnt;
  logic       mErr;
  logic [3:0] mSel;

  dbg_spi_slave dut (
    .i_nano_clk     (clk),
    .i_nano_rst     (rst),
    .i_dbg_spi_en_n (spi_en_n),
    .i_dbg_spi_sclk (spi_sclk),
    .i_dbg_spi_mosi (spi_mosi),
    .o_dbg_spi_miso (spi_miso),
    .o_wr_en        (wr_en),
    .o_wr_tgt       (wr_tgt),
    .o_wr_addr      (wr_addr),
    .o_wr_data      (wr_data),
    .o_core_rst     (core_rst),
    .o_clken_cfg    (clken_cfg),
    .o_rd_sel       (rd_sel),
    .i_rd_data      (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used for strobe latency measurement.
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nChecks++;
    if (obs !== expv) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Every write strobe must match the next model-predicted write, 4 clocks
  // after the final rising sclk of its data byte.
  always @(negedge clk) begin
    if (!rst && wr_en === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_strobe", {15'd0, wr_tgt, wr_addr, wr_data}, 32'd0);
      end else begin
        logic [16:0] e;
        e = expQ.pop_front();
        checkOutput("strobe", {15'd0, wr_tgt, wr_addr, wr_data}, {15'd0, e});
        checkOutput("strobe_latency", cycle - riseCycle, 4);
      end
    end
  end

  task automatic modelReset();
    mCore = 1'b1;
    mClk  = 8'h00;
    mCnt  = 0;
    mErr  = 1'b0;
    mSel  = 4'h0;
  endtask

  // Protocol-level effect of one (command, data) transaction.
  task automatic modelTxn(input logic [7:0] c, input logic [7:0] d);
    int size;
    logic [1:0] tgt;
    case (c[7:4])
      4'h0: begin
        mCore = d[0];
        mCnt  = 0;
        mErr  = 1'b0;
      end
      4'h2: mClk = d;
      4'h3, 4'h6, 4'h7: begin
        if (c[7:4] == 4'h3) begin tgt = 2'd3; size = 128; end
        else if (c[7:4] == 4'h6) begin tgt = 2'd0; size = 21; end
        else begin tgt = c[0] ? 2'd2 : 2'd1; size = 16; end
        if (mCnt < size) expQ.push_back({tgt, 7'(mCnt), d});
        else mErr = 1'b1;
        mCnt = (mCnt + 1) % 128;
      end
      4'h9: begin
`ifdef DBG_SPI_READBACK_EN
        mSel = c[3:0];
`endif
      end
      default: ;
    endcase
  endtask

  task automatic enLow();
    @(negedge clk);
    spi_en_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic enHigh();
    @(negedge clk);
    spi_en_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Shifts out the top nbits of tx; phases are 4 clocks each.
  task automatic spiByte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = tx[i];
      repeat (4) @(negedge clk);
      rx = {rx[6:0], spi_miso};
      spi_sclk = 1'b1;
      riseCycle = cycle;
      repeat (4) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] c, input logic [7:0] d, output logic [7:0] rx);
    logic [7:0] dummy;
    enLow();
    spiByte(c, 8, dummy);
    spiByte(d, 8, rx);
    enHigh();
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_core_rst"}, 32'(core_rst), 32'(mCore));
    checkOutput({tag, "_clken"}, 32'(clken_cfg), 32'(mClk));
    checkOutput({tag, "_rd_sel"}, 32'(rd_sel), 32'(mSel));
    checkOutput({tag, "_pending"}, expQ.size(), 0);
    checkOutput({tag, "_miso_idle"}, 32'(spi_miso), 0);
  endtask

  // Full transaction: predict, drive, then compare read byte and state.
  task automatic doTxn(input string tag, input logic [7:0] c, input logic [7:0] d);
    logic [7:0] expRd;
    logic [7:0] rx;
`ifdef DBG_SPI_READBACK_EN
    expRd = (c[7:4] != 4'h9) ? 8'h00 :
            (c[3:0] == 4'hF) ? {mErr, mCore, 6'b0} : rd_data;
`else
    expRd = 8'h00;
`endif
    modelTxn(c, d);
    applyStimulus(c, d, rx);
    if (c[7:4] == 4'h9) checkOutput({tag, "_rdbyte"}, 32'(rx), 32'(expRd));
    checkState(tag);
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] c;
    logic [3:0] dropOps[10];
    dropOps = '{4'h1, 4'h4, 4'h5, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    rst = 1'b1;
    spi_en_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    rd_data  = 8'h00;
    modelReset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_core_rst", 32'(core_rst), 1);
    checkOutput("rst_wr_en", 32'(wr_en), 0);
    checkOutput("rst_wr_tgt", 32'(wr_tgt), 0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 0);
    checkOutput("rst_wr_data", 32'(wr_data), 0);
    checkOutput("rst_clken", 32'(clken_cfg), 0);
    checkOutput("rst_rd_sel", 32'(rd_sel), 0);
    checkOutput("rst_miso", 32'(spi_miso), 0);

    $display("[TB] CLUT fill");
    doTxn("clr1", 8'h00, 8'h01);
    for (int k = 0; k < 21; k++) doTxn("clut", 8'h60, 8'(k));

    $display("[TB] SCHG shared counter");
    doTxn("clr2", 8'h00, 8'h01);
    doTxn("schg_lsb", 8'h70, 8'h34);
    doTxn("schg_msb", 8'h71, 8'h12);
    doTxn("release", 8'h00, 8'h00);

    $display("[TB] CLUT overflow and status");
    doTxn("clr3", 8'h00, 8'h01);
    for (int k = 0; k < 22; k++) doTxn("clut_ovf", 8'h60, 8'(8'h80 + k));
    doTxn("status", 8'h9F, 8'h00);

    $display("[TB] partial command discard");
    enLow();
    spiByte(8'h6F, 5, rx);
    enHigh();
    doTxn("after_part", 8'h20, 8'h03);

    $display("[TB] read i_rd_data");
    rd_data = 8'hA5;
    doTxn("rd_a5", 8'h90, 8'h3C);

    $display("[TB] back-to-back commands in one window");
    modelTxn(8'h20, 8'h11);
    modelTxn(8'h36, 8'h5E);
    enLow();
    spiByte(8'h20, 8, rx);
    spiByte(8'h11, 8, rx);
    spiByte(8'h36, 8, rx);
    spiByte(8'h5E, 8, rx);
    enHigh();
    checkState("b2b");

    $display("[TB] reset mid-transaction");
    enLow();
    spiByte(8'h20, 3, rx);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    modelReset();
    expQ.delete();
    spiByte(8'h20, 8, rx);
    spiByte(8'h77, 8, rx);
    enHigh();
    checkState("midrst");
    doTxn("post_rst", 8'h20, 8'h5A);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 60; n++) begin
      rd_data = 8'($urandom);
      case ($urandom_range(0, 9))
        0: c = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'h20;
        1: c = {4'h2, 4'($urandom)};
        2, 3: c = {4'h6, 4'($urandom)};
        4: c = {4'h7, 4'($urandom)};
        5: c = {4'h3, 4'($urandom)};
        6, 7: c = {4'h9, 4'($urandom)};
        default: c = {dropOps[$urandom_range(0, 9)], 4'($urandom)};
      endcase
      doTxn("rand", c, 8'($urandom));
    end

    repeat (10) @(negedge clk);
    checkOutput("final_pending", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
